// File: rtl/ws2812b_meter_frame_sched.sv
// ws2812b_meter_frame_sched
//   Frame-rate scheduler in front of the WS2812B meter serializer. Tracks the
//   peak audio level over each frame and scales it to an LED count. It applies
//   fall-rate limiting and peak-hold to that count, then launches one
//   serializer frame per frame tick.
//
// Ports
//   clk, reset_n      system clock, synchronous active-low reset
//   enable            run scheduler; 0 = idle
//   level/level_valid audio magnitude sample and its 1-cycle qualifier
//   led_total         LEDs on the strip (serializer maxCount)
//   ser_busy/ser_done serializer handshake inputs
//   frame_start       1-cycle serializer frame request
//   on_count          lit LED count, stable from frame_start until ser_done
//   peak_pos          peak-hold marker LED count
//   overrun_count     saturating count of dropped frame ticks
//   frame_active      high while a serializer frame is outstanding
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | scheduler disabled, accumulator cleared
// ACCUM     | collecting samples, waiting for the frame tick
// SCALE     | peak * led_total -> target LED count
// UPDATE    | apply decay / peak-hold to on_count and peak_pos
// LAUNCH    | wait for serializer idle, then pulse frame_start
// WAIT_DONE | serializer frame in flight, wait for ser_done
module ws2812b_meter_frame_sched #(
  parameter int unsigned FRAME_CYCLES = 1666667,
  parameter int unsigned DECAY_STEP   = 2,
  parameter int unsigned HOLD_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] level,
  input  logic        level_valid,
  input  logic [15:0] led_total,
  input  logic        ser_busy,
  input  logic        ser_done,
  output logic        frame_start,
  output logic [15:0] on_count,
  output logic [15:0] peak_pos,
  output logic [7:0]  overrun_count,
  output logic        frame_active
);

  localparam int unsigned TW = $clog2(FRAME_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(FRAME_CYCLES - 1);
  localparam logic [15:0] DSTEP = 16'(DECAY_STEP);
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCUM, S_SCALE, S_UPDATE, S_LAUNCH, S_WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] timer;
  logic [15:0]   peak_acc, sample, target, hold_cnt;
  logic          tick, accept, abort;

  assign tick = enable && (timer == TMAX);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    accept      = 1'b0;
    abort       = 1'b0;
    case (state)
      S_IDLE:
        if (enable) state_nxt = S_ACCUM;
      S_ACCUM:
        if (!enable) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else if (tick) begin
          accept    = 1'b1;
          state_nxt = S_SCALE;
        end
      S_SCALE:
        if (!enable) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else state_nxt = S_UPDATE;
      S_UPDATE:
        if (!enable) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else state_nxt = S_LAUNCH;
      S_LAUNCH:
        if (!enable) begin
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else if (!ser_busy) begin
          frame_start = 1'b1;
          state_nxt   = S_WAIT_DONE;
        end
      // enable=0 is honoured only once the serializer has finished.
      S_WAIT_DONE:
        if (ser_done) state_nxt = enable ? S_ACCUM : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || !enable) timer <= '0;
    else if (timer == TMAX)  timer <= '0;
    else                     timer <= timer + 1'b1;
  end

  // Samples that arrive after a tick (SCALE..WAIT_DONE) belong to the next
  // frame, so the accumulator only clears on accept, idle or abort.
  always_ff @(posedge clk) begin
    if (!reset_n || state == S_IDLE || abort || accept)
      peak_acc <= '0;
    else if (level_valid && level > peak_acc)
      peak_acc <= level;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      sample <= '0;
    else if (accept)
      sample <= (level_valid && level > peak_acc) ? level : peak_acc;
  end

  // (sample * led_total) >> 16 is always below led_total; the clamp only
  // guards the degenerate led_total = 0 case.
  logic [15:0] scaled;
  assign scaled = 16'((32'(sample) * 32'(led_total)) >> 16);

  always_ff @(posedge clk) begin
    if (!reset_n)
      target <= '0;
    else if (state == S_SCALE)
      target <= (scaled > led_total) ? led_total : scaled;
  end

  logic [15:0] on_sel, on_new, pk_sel, pk_max, pk_new, hold_new;

  always_comb begin
    on_sel   = target;
    hold_new = hold_cnt;
    pk_sel   = peak_pos;
    // on_count - min(DSTEP, on_count - target)
    if (target < on_count)
      on_sel = ((on_count - target) > DSTEP) ? on_count - DSTEP : target;
    on_new = (on_sel > led_total) ? led_total : on_sel;

    if (target >= peak_pos) begin
      pk_sel   = target;
      hold_new = HOLD_INIT;
    end else if (hold_cnt != '0) begin
      hold_new = hold_cnt - 1'b1;
    end else begin
      pk_sel = peak_pos - 1'b1;
    end
    pk_max = (pk_sel < on_new) ? on_new : pk_sel;
    pk_new = (pk_max > led_total) ? led_total : pk_max;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      on_count <= '0;
      peak_pos <= '0;
      hold_cnt <= '0;
    end else if (state == S_UPDATE && enable) begin
      on_count <= on_new;
      peak_pos <= pk_new;
      hold_cnt <= hold_new;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      overrun_count <= '0;
    else if (tick && state != S_ACCUM && overrun_count != 8'hFF)
      overrun_count <= overrun_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      frame_active <= 1'b0;
    else if (frame_start)
      frame_active <= 1'b1;
    else if (state == S_WAIT_DONE && ser_done)
      frame_active <= 1'b0;
  end

endmodule

// File: tb/tb_ws2812b_meter_frame_sched.sv
// Directed bench for ws2812b_meter_frame_sched (FRAME_CYCLES=16,
// DECAY_STEP=2, HOLD_FRAMES=2). ph tracks the expected frame timer phase;
// ph==15 is the tick cycle.
module tb_ws2812b_meter_frame_sched;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] level;
  logic        level_valid;
  logic [15:0] led_total;
  logic        ser_busy;
  logic        ser_done;
  logic        frame_start;
  logic [15:0] on_count;
  logic [15:0] peak_pos;
  logic [7:0]  overrun_count;
  logic        frame_active;

  int checks = 0;
  int failures = 0;
  int ph = 0;
  int starts;
  int lat;
  logic fa_mid, fa_after;
  int dec_on [5] = '{59, 57, 55, 53, 51};
  int dec_pk [5] = '{59, 59, 59, 58, 57};

  ws2812b_meter_frame_sched #(
    .FRAME_CYCLES(16),
    .DECAY_STEP(2),
    .HOLD_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .level(level),
    .level_valid(level_valid),
    .led_total(led_total),
    .ser_busy(ser_busy),
    .ser_done(ser_done),
    .frame_start(frame_start),
    .on_count(on_count),
    .peak_pos(peak_pos),
    .overrun_count(overrun_count),
    .frame_active(frame_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the edge.
  task automatic nxt();
    int pn;
    pn = (!reset_n || !enable) ? 0 : ((ph == 15) ? 0 : ph + 1);
    @(posedge clk);
    ph = pn;
    #1;
  endtask

  // Run until the tick cycle, offering up to three samples early in the frame.
  task automatic collect(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [2:0] v);
    for (int i = 0; i < 40; i++) begin
      nxt();
      level_valid = 1'b0;
      level = 16'd0;
      case (i)
        0: begin level = a; level_valid = v[0]; end
        2: begin level = b; level_valid = v[1]; end
        4: begin level = c; level_valid = v[2]; end
        default: ;
      endcase
      if (ph == 15) break;
    end
  endtask

  // From the tick cycle: find frame_start (latency in cycles), then optionally
  // answer with ser_done done_delay cycles later.
  task automatic launch(input int done_delay, output int lat_o,
                        output logic fa_mid_o, output logic fa_after_o);
    lat_o = -1;
    fa_mid_o = 1'b0;
    fa_after_o = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      nxt();
      level_valid = 1'b0;
      level = 16'd0;
      #2;
      if (frame_start === 1'b1) begin
        lat_o = i;
        break;
      end
    end
    if (done_delay > 0 && lat_o > 0) begin
      for (int j = 1; j <= done_delay; j++) begin
        nxt();
        if (j == done_delay) ser_done = 1'b1;
      end
      #2;
      fa_mid_o = frame_active;
      nxt();
      ser_done = 1'b0;
      #2;
      fa_after_o = frame_active;
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; level = 16'd0; level_valid = 1'b0;
    led_total = 16'd0; ser_busy = 1'b0; ser_done = 1'b0;
    nxt(); nxt(); nxt();
    #2;
    check("rst_active", frame_active, 0);
    check("rst_overrun", overrun_count, 0);
    reset_n = 1'b1;
    led_total = 16'd60;

    // Idle: enable low for 100 cycles
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      nxt(); #2;
      if (frame_start === 1'b1) starts++;
    end
    check("idle_starts", starts, 0);
    check("idle_on", on_count, 0);
    check("idle_peak", peak_pos, 0);
    check("idle_overrun", overrun_count, 0);
    check("idle_active", frame_active, 0);

    // Scaling: 0x8000 * 60 >> 16 = 30
    enable = 1'b1;
    collect(16'h8000, 16'd0, 16'd0, 3'b001);
    launch(5, lat, fa_mid, fa_after);
    check("scale_latency", lat, 3);
    check("scale_on", on_count, 30);
    check("scale_peak", peak_pos, 30);
    check("scale_active_at_done", fa_mid, 1);
    check("scale_active_after", fa_after, 0);

    // Peak per frame: max(0x1000,0xC000,0x4000)=0xC000, *100>>16 = 75
    led_total = 16'd100;
    collect(16'h1000, 16'hC000, 16'h4000, 3'b111);
    launch(5, lat, fa_mid, fa_after);
    check("peak_on", on_count, 75);
    check("peak_peak", peak_pos, 75);

    // Abort: enable drops in SCALE
    collect(16'h1000, 16'd0, 16'd0, 3'b001);
    nxt();
    enable = 1'b0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      nxt(); #2;
      if (frame_start === 1'b1) starts++;
    end
    check("abort_starts", starts, 0);
    check("abort_on", on_count, 75);
    check("abort_peak", peak_pos, 75);
    check("abort_active", frame_active, 0);

    // led_total = 0: frame still launched, outputs forced to 0
    led_total = 16'd0;
    enable = 1'b1;
    collect(16'hFFFF, 16'd0, 16'd0, 3'b001);
    launch(5, lat, fa_mid, fa_after);
    check("zero_latency", lat, 3);
    check("zero_on", on_count, 0);
    check("zero_peak", peak_pos, 0);

    // Decay / hold from a fresh reset
    reset_n = 1'b0; enable = 1'b0;
    nxt(); nxt();
    reset_n = 1'b1; led_total = 16'd60; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) collect(16'hFFFF, 16'd0, 16'd0, 3'b001);
      else        collect(16'd0, 16'd0, 16'd0, 3'b000);
      launch(5, lat, fa_mid, fa_after);
      check($sformatf("decay_on%0d", k), on_count, dec_on[k]);
      check($sformatf("decay_peak%0d", k), peak_pos, dec_pk[k]);
    end

    // Overrun: withhold ser_done for 3 frame periods
    check("ovr_initial", overrun_count, 0);
    collect(16'd0, 16'd0, 16'd0, 3'b000);
    launch(0, lat, fa_mid, fa_after);
    starts = 0;
    for (int i = 0; i < 48; i++) begin
      nxt(); #2;
      if (frame_start === 1'b1) starts++;
    end
    check("ovr_starts", starts, 0);
    check("ovr_count3", overrun_count, 3);
    check("ovr_active", frame_active, 1);
    nxt(); ser_done = 1'b1;
    nxt(); ser_done = 1'b0;
    collect(16'd0, 16'd0, 16'd0, 3'b000);
    launch(5, lat, fa_mid, fa_after);
    check("ovr_resume_latency", lat, 3);
    check("ovr_count_hold", overrun_count, 3);

    // Tick in the same cycle as ser_done is an overrun
    collect(16'd0, 16'd0, 16'd0, 3'b000);
    launch(0, lat, fa_mid, fa_after);
    for (int i = 0; i < 20; i++) begin
      nxt();
      if (ph == 15) begin
        ser_done = 1'b1;
        break;
      end
    end
    nxt(); ser_done = 1'b0; #2;
    check("ovr_tick_with_done", overrun_count, 4);
    check("ovr_done_active", frame_active, 0);

    // Saturation: 300 more skipped ticks
    collect(16'd0, 16'd0, 16'd0, 3'b000);
    launch(0, lat, fa_mid, fa_after);
    for (int i = 0; i < 4800; i++) nxt();
    #2;
    check("ovr_saturate", overrun_count, 255);
    nxt(); ser_done = 1'b1;
    nxt(); ser_done = 1'b0;

    // Busy hold-off: serializer busy for the first 10 LAUNCH cycles
    collect(16'd0, 16'd0, 16'd0, 3'b000);
    ser_busy = 1'b1;
    starts = 0;
    for (int i = 1; i <= 12; i++) begin
      nxt(); level_valid = 1'b0; #2;
      if (frame_start === 1'b1) starts++;
    end
    nxt(); ser_busy = 1'b0; #2;
    check("busy_early_starts", starts, 0);
    check("busy_release_start", frame_start, 1);
    nxt(); ser_done = 1'b1;
    nxt(); ser_done = 1'b0;

    // Reset mid-frame drops frame_active without ser_done
    collect(16'd0, 16'd0, 16'd0, 3'b000);
    launch(0, lat, fa_mid, fa_after);
    nxt(); #2;
    check("mid_active", frame_active, 1);
    reset_n = 1'b0;
    nxt(); #2;
    check("midrst_active", frame_active, 0);
    check("midrst_overrun", overrun_count, 0);
    check("midrst_on", on_count, 0);
    check("midrst_peak", peak_pos, 0);
    reset_n = 1'b1; enable = 1'b0;
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
